// File: rtl/spi_disp_pkg.sv
// Shared definitions for the SPI display link (receiver and transmit-side sequencers).
//   - Command codes of the supported ILI9341-style subset
//   - Receiver decoder state encoding
//   - Received byte payload (data + DC flag)
//   - Common RGB565 colours
package spi_disp_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam logic [15:0] RGB_BLACK = 16'h0000;
  localparam logic [15:0] RGB_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB_RED   = 16'hF800;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CASET_P = 3'd1,
    ST_PASET_P = 3'd2,
    ST_RAMWR   = 3'd3,
    ST_IGNORE  = 3'd4
  } dec_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       dc;
  } spi_byte_t;

endpackage

// File: rtl/spi_byte_rx.sv
// Serial-to-byte front end of the display receiver.
// Synchronizes SCK/MOSI/CS/DC into clk, qualifies SCK rising edges with CS low,
// shifts MOSI in MSB first and emits one byte per 8 qualified edges.
// Ports:
//   clk, rst_n           : system clock, async active-low reset
//   sck, mosi, cs, dc    : raw SPI pins (asynchronous to clk)
//   byte_valid           : one-cycle pulse, rx_byte holds a completed byte
//   rx_byte              : byte data plus DC captured with its last bit
//   cs_abort             : one-cycle pulse on a CS rising edge (partial byte dropped)
module spi_byte_rx
  import spi_disp_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      sck,
  input  logic      mosi,
  input  logic      cs,
  input  logic      dc,
  output logic      byte_valid,
  output spi_byte_t rx_byte,
  output logic      cs_abort
);

  // [0],[1] form the two-flop synchronizer; [2] is history for edge detect
  // and keeps MOSI/DC aligned with the registered edge strobe.
  logic [2:0] sck_sync;
  logic [2:0] mosi_sync;
  logic [2:0] cs_sync;
  logic [2:0] dc_sync;

  logic       rise_q;
  logic       cs_rise_q;
  logic [6:0] shreg;
  logic [2:0] bit_cnt;

  // Synchronizers; CS resets deasserted so no edge is seen out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= 3'b000;
      mosi_sync <= 3'b000;
      cs_sync   <= 3'b111;
      dc_sync   <= 3'b000;
    end else begin
      sck_sync  <= {sck_sync[1:0], sck};
      mosi_sync <= {mosi_sync[1:0], mosi};
      cs_sync   <= {cs_sync[1:0], cs};
      dc_sync   <= {dc_sync[1:0], dc};
    end
  end

  // Registered edge strobes; aligned with mosi_sync[2]/dc_sync[2] one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q    <= 1'b0;
      cs_rise_q <= 1'b0;
    end else begin
      rise_q    <= sck_sync[1] & ~sck_sync[2] & ~cs_sync[1];
      cs_rise_q <= cs_sync[1] & ~cs_sync[2];
    end
  end

  // Shift register and bit counter; a CS rise clears the count after any completing byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= 7'd0;
      bit_cnt    <= 3'd0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
      cs_abort   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      cs_abort   <= cs_rise_q;
      if (rise_q) begin
        shreg <= {shreg[5:0], mosi_sync[2]};
        if (bit_cnt == 3'd7) begin
          byte_valid   <= 1'b1;
          rx_byte.data <= {shreg, mosi_sync[2]};
          rx_byte.dc   <= dc_sync[2];
          bit_cnt      <= 3'd0;
        end else begin
          bit_cnt <= 3'(bit_cnt + 3'd1);
        end
      end
      if (cs_rise_q) begin
        bit_cnt <= 3'd0;
      end
    end
  end

endmodule

// File: rtl/spi_display_rx.sv
// SPI display-side receiver: turns the 4-wire display stream into command and
// pixel-write events for the CASET/PASET/RAMWR subset.
// Ports:
//   i_clk, i_rst               : system clock, async active-low reset
//   i_sck, i_mosi, i_cs, i_dc  : SPI pins (CS active-low, DC 0 = command)
//   o_cmd_valid, o_cmd         : pulse per command byte, last command code (held)
//   o_pix_valid                : pulse per completed RGB565 pixel
//   o_pix_x, o_pix_y           : pixel coordinates, valid with o_pix_valid
//   o_pix_color                : pixel colour, first byte in [15:8]
//   o_win_err                  : sticky, window committed with start > end
module spi_display_rx
  import spi_disp_pkg::*;
#(
  parameter int unsigned WIDTH   = 240,
  parameter int unsigned HEIGHT  = 320,
  parameter int unsigned COORD_W = 9
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_sck,
  input  logic               i_mosi,
  input  logic               i_cs,
  input  logic               i_dc,
  output logic               o_cmd_valid,
  output logic [7:0]         o_cmd,
  output logic               o_pix_valid,
  output logic [COORD_W-1:0] o_pix_x,
  output logic [COORD_W-1:0] o_pix_y,
  output logic [15:0]        o_pix_color,
  output logic               o_win_err
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(HEIGHT - 1);

  logic      byte_valid;
  spi_byte_t rx_byte;
  logic      cs_abort;

  spi_byte_rx u_byte_rx (
    .clk        (i_clk),
    .rst_n      (i_rst),
    .sck        (i_sck),
    .mosi       (i_mosi),
    .cs         (i_cs),
    .dc         (i_dc),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .cs_abort   (cs_abort)
  );

  dec_state_e         state_q, state_n;
  logic [1:0]         idx_q, idx_n;
  logic [23:0]        prm_q, prm_n;
  logic [COORD_W-1:0] xs_q, xs_n, xe_q, xe_n, ys_q, ys_n, ye_q, ye_n;
  logic [COORD_W-1:0] cx_q, cx_n, cy_q, cy_n;
  logic               half_q, half_n;
  logic [7:0]         hi_q, hi_n;

  logic               cmd_valid_n;
  logic [7:0]         cmd_n;
  logic               pix_valid_n;
  logic [COORD_W-1:0] pix_x_n, pix_y_n;
  logic [15:0]        pix_color_n;
  logic               win_err_n;

  // Window parameters as seen when the 4th byte arrives; bad range collapses to start.
  logic [15:0]        p_start_c, p_end_c;
  logic [COORD_W-1:0] w_start_c, w_end_raw_c, w_end_c;
  logic               w_bad_c;

  assign p_start_c   = prm_q[23:8];
  assign p_end_c     = {prm_q[7:0], rx_byte.data};
  assign w_start_c   = COORD_W'(p_start_c);
  assign w_end_raw_c = COORD_W'(p_end_c);
  assign w_bad_c     = (w_start_c > w_end_raw_c);
  assign w_end_c     = w_bad_c ? w_start_c : w_end_raw_c;

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      prm_q       <= 24'd0;
      xs_q        <= '0;
      xe_q        <= X_MAX;
      ys_q        <= '0;
      ye_q        <= Y_MAX;
      cx_q        <= '0;
      cy_q        <= '0;
      half_q      <= 1'b0;
      hi_q        <= 8'd0;
      o_cmd_valid <= 1'b0;
      o_cmd       <= 8'd0;
      o_pix_valid <= 1'b0;
      o_pix_x     <= '0;
      o_pix_y     <= '0;
      o_pix_color <= RGB_BLACK;
      o_win_err   <= 1'b0;
    end else begin
      state_q     <= state_n;
      idx_q       <= idx_n;
      prm_q       <= prm_n;
      xs_q        <= xs_n;
      xe_q        <= xe_n;
      ys_q        <= ys_n;
      ye_q        <= ye_n;
      cx_q        <= cx_n;
      cy_q        <= cy_n;
      half_q      <= half_n;
      hi_q        <= hi_n;
      o_cmd_valid <= cmd_valid_n;
      o_cmd       <= cmd_n;
      o_pix_valid <= pix_valid_n;
      o_pix_x     <= pix_x_n;
      o_pix_y     <= pix_y_n;
      o_pix_color <= pix_color_n;
      o_win_err   <= win_err_n;
    end
  end

  // Command decoder, window commit and pixel cursor.
  always_comb begin
    state_n     = state_q;
    idx_n       = idx_q;
    prm_n       = prm_q;
    xs_n        = xs_q;
    xe_n        = xe_q;
    ys_n        = ys_q;
    ye_n        = ye_q;
    cx_n        = cx_q;
    cy_n        = cy_q;
    half_n      = half_q;
    hi_n        = hi_q;
    cmd_valid_n = 1'b0;
    cmd_n       = o_cmd;
    pix_valid_n = 1'b0;
    pix_x_n     = o_pix_x;
    pix_y_n     = o_pix_y;
    pix_color_n = o_pix_color;
    win_err_n   = o_win_err;

    if (byte_valid) begin
      if (!rx_byte.dc) begin
        // Any command aborts whatever was in progress.
        cmd_valid_n = 1'b1;
        cmd_n       = rx_byte.data;
        idx_n       = 2'd0;
        half_n      = 1'b0;
        case (rx_byte.data)
          CMD_CASET: state_n = ST_CASET_P;
          CMD_PASET: state_n = ST_PASET_P;
          CMD_RAMWR: begin
            state_n = ST_RAMWR;
            cx_n    = xs_q;
            cy_n    = ys_q;
          end
          default:   state_n = ST_IGNORE;
        endcase
      end else begin
        case (state_q)
          ST_CASET_P, ST_PASET_P: begin
            prm_n = {prm_q[15:0], rx_byte.data};
            if (idx_q == 2'd3) begin
              if (w_bad_c) begin
                win_err_n = 1'b1;
              end
              if (state_q == ST_CASET_P) begin
                xs_n = w_start_c;
                xe_n = w_end_c;
              end else begin
                ys_n = w_start_c;
                ye_n = w_end_c;
              end
              state_n = ST_IGNORE;
            end else begin
              idx_n = 2'(idx_q + 2'd1);
            end
          end
          ST_RAMWR: begin
            if (!half_q) begin
              hi_n   = rx_byte.data;
              half_n = 1'b1;
            end else begin
              half_n      = 1'b0;
              pix_valid_n = 1'b1;
              pix_x_n     = cx_q;
              pix_y_n     = cy_q;
              pix_color_n = {hi_q, rx_byte.data};
              // Raster advance inside the window; wraps silently at the end.
              if (cx_q == xe_q) begin
                cx_n = xs_q;
                cy_n = (cy_q == ye_q) ? ys_q : COORD_W'(cy_q + COORD_W'(1));
              end else begin
                cx_n = COORD_W'(cx_q + COORD_W'(1));
              end
            end
          end
          default: ;
        endcase
      end
    end

    // CS rise drops a pending half-pixel after any byte completing this cycle.
    if (cs_abort) begin
      half_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_display_rx.sv
// Directed self-checking bench for spi_display_rx.
module tb_spi_display_rx;
  import spi_disp_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_sck = 1'b0;
  logic        i_mosi = 1'b0;
  logic        i_cs = 1'b1;
  logic        i_dc = 1'b0;
  logic        o_cmd_valid;
  logic [7:0]  o_cmd;
  logic        o_pix_valid;
  logic [8:0]  o_pix_x;
  logic [8:0]  o_pix_y;
  logic [15:0] o_pix_color;
  logic        o_win_err;

  int errors = 0;
  int checks = 0;

  logic [7:0]  cmd_q[$];
  logic [33:0] pix_q[$];

  spi_display_rx #(.WIDTH(240), .HEIGHT(320), .COORD_W(9)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_sck       (i_sck),
    .i_mosi      (i_mosi),
    .i_cs        (i_cs),
    .i_dc        (i_dc),
    .o_cmd_valid (o_cmd_valid),
    .o_cmd       (o_cmd),
    .o_pix_valid (o_pix_valid),
    .o_pix_x     (o_pix_x),
    .o_pix_y     (o_pix_y),
    .o_pix_color (o_pix_color),
    .o_win_err   (o_win_err)
  );

  always #5 i_clk = ~i_clk;

  // Record every pulse, sampled on the falling edge.
  always @(negedge i_clk) begin
    if (o_cmd_valid) cmd_q.push_back(o_cmd);
    if (o_pix_valid) pix_q.push_back({o_pix_x, o_pix_y, o_pix_color});
  end

  // SCK phases of 40 ns (4 clk cycles); SCK always left low.
  task automatic send_byte(input logic [7:0] b, input logic d);
    i_cs = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      i_mosi = b[i];
      i_dc   = d;
      #40 i_sck = 1'b1;
      #40 i_sck = 1'b0;
    end
  endtask

  task automatic cs_release();
    #40 i_cs = 1'b1;
    #80;
  endtask

  task automatic settle();
    #200;
  endtask

  task automatic clear_q();
    cmd_q.delete();
    pix_q.delete();
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    #23;
    checks++; if (o_cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid got=%b exp=0", o_cmd_valid); end
    checks++; if (o_cmd !== 8'h00) begin errors++; $display("FAIL reset_cmd got=%h exp=00", o_cmd); end
    checks++; if (o_pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid got=%b exp=0", o_pix_valid); end
    checks++; if (o_pix_x !== 9'd0 || o_pix_y !== 9'd0) begin errors++; $display("FAIL reset_pix_xy got=%0d,%0d exp=0,0", o_pix_x, o_pix_y); end
    checks++; if (o_pix_color !== 16'h0000) begin errors++; $display("FAIL reset_pix_color got=%h exp=0000", o_pix_color); end
    checks++; if (o_win_err !== 1'b0) begin errors++; $display("FAIL reset_win_err got=%b exp=0", o_win_err); end
    @(negedge i_clk);
    i_rst = 1'b1;
    #50;
  endtask

  task automatic test_first_pixel();
    clear_q();
    send_byte(CMD_RAMWR, 1'b0);
    send_byte(8'hF8, 1'b1);
    send_byte(8'h00, 1'b1);
    cs_release();
    settle();
    checks++; if (cmd_q.size() !== 1) begin errors++; $display("FAIL first_cmd_count got=%0d exp=1", cmd_q.size()); end
    else begin
      checks++; if (cmd_q[0] !== 8'h2C) begin errors++; $display("FAIL first_cmd_code got=%h exp=2c", cmd_q[0]); end
    end
    checks++; if (pix_q.size() !== 1) begin errors++; $display("FAIL first_pix_count got=%0d exp=1", pix_q.size()); end
    else begin
      checks++; if (pix_q[0] !== {9'd0, 9'd0, RGB_RED}) begin errors++; $display("FAIL first_pix got=%h exp=%h", pix_q[0], {9'd0, 9'd0, RGB_RED}); end
    end
  endtask

  task automatic test_window();
    logic [33:0] exp_pix [0:5];
    exp_pix[0] = {9'd10, 9'd20, RGB_WHITE};
    exp_pix[1] = {9'd11, 9'd20, RGB_WHITE};
    exp_pix[2] = {9'd12, 9'd20, RGB_WHITE};
    exp_pix[3] = {9'd10, 9'd21, RGB_WHITE};
    exp_pix[4] = {9'd11, 9'd21, RGB_WHITE};
    exp_pix[5] = {9'd12, 9'd21, RGB_WHITE};
    clear_q();
    send_byte(CMD_CASET, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h0A, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h0C, 1'b1);
    send_byte(CMD_PASET, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h14, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h15, 1'b1);
    send_byte(CMD_RAMWR, 1'b0);
    for (int i = 0; i < 6; i++) begin
      send_byte(8'hFF, 1'b1);
      send_byte(8'hFF, 1'b1);
    end
    settle();
    checks++; if (cmd_q.size() !== 3) begin errors++; $display("FAIL win_cmd_count got=%0d exp=3", cmd_q.size()); end
    checks++; if (o_cmd !== 8'h2C) begin errors++; $display("FAIL win_cmd_held got=%h exp=2c", o_cmd); end
    checks++; if (pix_q.size() !== 6) begin errors++; $display("FAIL win_pix_count got=%0d exp=6", pix_q.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (pix_q[i] !== exp_pix[i]) begin errors++; $display("FAIL win_pix%0d got=%h exp=%h", i, pix_q[i], exp_pix[i]); end
      end
    end
  endtask

  task automatic test_wrap();
    clear_q();
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    cs_release();
    settle();
    checks++; if (pix_q.size() !== 1) begin errors++; $display("FAIL wrap_pix_count got=%0d exp=1", pix_q.size()); end
    else begin
      checks++; if (pix_q[0] !== {9'd10, 9'd20, RGB_WHITE}) begin errors++; $display("FAIL wrap_pix got=%h exp=%h", pix_q[0], {9'd10, 9'd20, RGB_WHITE}); end
    end
    checks++; if (o_win_err !== 1'b0) begin errors++; $display("FAIL wrap_win_err got=%b exp=0", o_win_err); end
  endtask

  task automatic test_bad_window();
    logic [33:0] exp_pix [0:2];
    exp_pix[0] = {9'd50, 9'd20, 16'h001F};
    exp_pix[1] = {9'd50, 9'd21, 16'h001F};
    exp_pix[2] = {9'd50, 9'd20, 16'h001F};
    clear_q();
    send_byte(CMD_CASET, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h32, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h28, 1'b1);
    settle();
    checks++; if (o_win_err !== 1'b1) begin errors++; $display("FAIL bad_win_err got=%b exp=1", o_win_err); end
    send_byte(CMD_RAMWR, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h00, 1'b1);
      send_byte(8'h1F, 1'b1);
    end
    cs_release();
    settle();
    checks++; if (pix_q.size() !== 3) begin errors++; $display("FAIL bad_pix_count got=%0d exp=3", pix_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (pix_q[i] !== exp_pix[i]) begin errors++; $display("FAIL bad_pix%0d got=%h exp=%h", i, pix_q[i], exp_pix[i]); end
      end
    end
  endtask

  task automatic test_cs_abort();
    logic [7:0] junk;
    junk = 8'hC5;
    clear_q();
    i_cs = 1'b0;
    #40;
    for (int i = 7; i >= 3; i--) begin
      i_mosi = junk[i];
      i_dc   = 1'b0;
      #40 i_sck = 1'b1;
      #40 i_sck = 1'b0;
    end
    cs_release();
    send_byte(CMD_CASET, 1'b0);
    cs_release();
    settle();
    checks++; if (cmd_q.size() !== 1) begin errors++; $display("FAIL abort_cmd_count got=%0d exp=1", cmd_q.size()); end
    else begin
      checks++; if (cmd_q[0] !== 8'h2A) begin errors++; $display("FAIL abort_cmd_code got=%h exp=2a", cmd_q[0]); end
    end
    checks++; if (o_cmd !== 8'h2A) begin errors++; $display("FAIL abort_cmd_held got=%h exp=2a", o_cmd); end
  endtask

  task automatic test_reset_mid_ramwr();
    clear_q();
    send_byte(CMD_RAMWR, 1'b0);
    send_byte(8'hAB, 1'b1);
    settle();
    @(negedge i_clk);
    i_rst = 1'b0;
    #2;
    checks++; if (o_cmd !== 8'h00) begin errors++; $display("FAIL rst_mid_cmd got=%h exp=00", o_cmd); end
    checks++; if (o_win_err !== 1'b0) begin errors++; $display("FAIL rst_mid_win_err got=%b exp=0", o_win_err); end
    checks++; if (o_pix_color !== 16'h0000) begin errors++; $display("FAIL rst_mid_color got=%h exp=0000", o_pix_color); end
    checks++; if (o_cmd_valid !== 1'b0 || o_pix_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valids got=%b%b exp=00", o_cmd_valid, o_pix_valid); end
    #30;
    @(negedge i_clk);
    i_rst = 1'b1;
    #50;
    clear_q();
    send_byte(8'hCD, 1'b1);
    send_byte(8'hEF, 1'b1);
    settle();
    checks++; if (pix_q.size() !== 0 || cmd_q.size() !== 0) begin errors++; $display("FAIL rst_drop got=%0d/%0d exp=0/0", pix_q.size(), cmd_q.size()); end
    send_byte(CMD_RAMWR, 1'b0);
    send_byte(8'h07, 1'b1);
    send_byte(8'hE0, 1'b1);
    cs_release();
    settle();
    checks++; if (pix_q.size() !== 1) begin errors++; $display("FAIL rst_new_pix_count got=%0d exp=1", pix_q.size()); end
    else begin
      checks++; if (pix_q[0] !== {9'd0, 9'd0, 16'h07E0}) begin errors++; $display("FAIL rst_new_pix got=%h exp=%h", pix_q[0], {9'd0, 9'd0, 16'h07E0}); end
    end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_window();
    test_wrap();
    test_bad_window();
    test_cs_abort();
    test_reset_mid_ramwr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
